// File: rtl/demux_router.sv
// One-to-many valid/ready router: each accepted beat is steered to the lane
// named by in_sel and held in that lane's one-entry buffer until drained.
module demux_router #(
   parameter int DATA_W    = 2,
   parameter int SEL_W     = 5,
   parameter int NUM_LANES = 32,
   parameter int CNT_W     = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [SEL_W-1:0]              in_sel,
   input  logic [DATA_W-1:0]             in_data,
   output logic [NUM_LANES-1:0]          out_valid,
   input  logic [NUM_LANES-1:0]          out_ready,
   output logic [NUM_LANES*DATA_W-1:0]   out_data,
   output logic [CNT_W-1:0]              drop_cnt
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } lane_state_e;

   localparam logic [SEL_W:0] LANES_LIM = (SEL_W+1)'(NUM_LANES);

   logic                 sel_in_range;
   logic                 drop;
   logic [NUM_LANES-1:0] sel_hit;
   logic [NUM_LANES-1:0] lane_free;
   logic [NUM_LANES-1:0] load;
   logic [CNT_W-1:0]     drop_cnt_q;
   logic [CNT_W-1:0]     drop_cnt_d;

   // Out-of-range selects are always accepted so a bad producer cannot stall.
   assign sel_in_range = ({1'b0, in_sel} < LANES_LIM);
   assign in_ready     = sel_in_range ? |(sel_hit & lane_free) : 1'b1;
   assign drop         = in_valid & ~sel_in_range;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      lane_state_e       state_q;
      lane_state_e       state_d;
      logic [DATA_W-1:0] data_q;
      logic [DATA_W-1:0] data_d;
      logic              lane_valid;

      assign sel_hit[g]   = (in_sel == SEL_W'(g));
      assign lane_free[g] = (state_q == EMPTY) | out_ready[g];
      assign load[g]      = in_valid & in_ready & sel_hit[g];

      // NOTE: data is reset too so out_data reads zero immediately on reset.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
         end else begin
            // NOTE: non-blocking so every lane samples the same pre-edge values.
            state_q <= state_d;
            data_q  <= data_d;
         end
      end

      always_comb begin
         // NOTE: defaults first so no path through the case infers a latch.
         state_d = state_q;
         data_d  = data_q;
         if (load[g]) begin
            data_d = in_data;
         end
         unique case (state_q)
            EMPTY: if (load[g]) state_d = FULL;
            FULL: begin
               if (load[g])           state_d = FULL;
               else if (out_ready[g]) state_d = EMPTY;
            end
            default: state_d = EMPTY;
         endcase
      end

      always_comb begin
         lane_valid = (state_q == FULL);
      end

      assign out_valid[g]                 = lane_valid;
      assign out_data[g*DATA_W +: DATA_W] = data_q;
   end

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_router.sv
// Directed and random checks for demux_router: a 32-lane instance for routing
// and a 30-lane instance for out-of-range drop behaviour.
module tb_demux_router;

   localparam int DATA_W = 2;
   localparam int SEL_W  = 5;
   localparam int NL     = 32;
   localparam int NL_D   = 30;
   localparam int CNT_W  = 8;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;

   logic                  in_valid;
   logic                  in_ready;
   logic [SEL_W-1:0]      in_sel;
   logic [DATA_W-1:0]     in_data;
   logic [NL-1:0]         out_valid;
   logic [NL-1:0]         out_ready;
   logic [NL*DATA_W-1:0]  out_data;
   logic [CNT_W-1:0]      drop_cnt;

   logic                  d_in_valid;
   logic                  d_in_ready;
   logic [SEL_W-1:0]      d_in_sel;
   logic [DATA_W-1:0]     d_in_data;
   logic [NL_D-1:0]       d_out_valid;
   logic [NL_D-1:0]       d_out_ready;
   logic [NL_D*DATA_W-1:0] d_out_data;
   logic [CNT_W-1:0]      d_drop_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   demux_router #(.DATA_W(DATA_W), .SEL_W(SEL_W), .NUM_LANES(NL), .CNT_W(CNT_W)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .drop_cnt(drop_cnt)
   );

   demux_router #(.DATA_W(DATA_W), .SEL_W(SEL_W), .NUM_LANES(NL_D), .CNT_W(CNT_W)) u_drop (
      .clk(clk), .rst_n(rst_n),
      .in_valid(d_in_valid), .in_ready(d_in_ready), .in_sel(d_in_sel), .in_data(d_in_data),
      .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
      .drop_cnt(d_drop_cnt)
   );

   function automatic logic [DATA_W-1:0] lane(input logic [NL*DATA_W-1:0] v, input int i);
      return v[i*DATA_W +: DATA_W];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid   = 1'b0;
      in_sel     = '0;
      in_data    = '0;
      d_in_valid = 1'b0;
      d_in_sel   = '0;
      d_in_data  = '0;
   endtask

   task automatic test_reset();
      logic [NL-1:0] exp_v;
      idle();
      out_ready   = '0;
      d_out_ready = '0;
      rst_n       = 1'b0;
      #1;
      checks++;
      if (out_valid !== '0 || out_data !== '0 || drop_cnt !== '0) begin
         errors++;
         $display("FAIL reset_init: valid=%h data=%h drop=%0d, want all zero", out_valid, out_data, drop_cnt);
      end
      step();
      step();
      rst_n = 1'b1;
      // Fill lanes 3 and 7 with stalled consumers, and drop two beats on the 30-lane DUT.
      in_valid = 1'b1; in_sel = 5'd3; in_data = 2'd1;
      d_in_valid = 1'b1; d_in_sel = 5'd31;
      step();
      in_sel = 5'd7; in_data = 2'd2;
      step();
      idle();
      exp_v = '0; exp_v[3] = 1'b1; exp_v[7] = 1'b1;
      checks++;
      if (out_valid !== exp_v || lane(out_data, 3) !== 2'd1 || lane(out_data, 7) !== 2'd2) begin
         errors++;
         $display("FAIL reset_prefill: valid=%h l3=%0d l7=%0d, want %h l3=1 l7=2",
                  out_valid, lane(out_data, 3), lane(out_data, 7), exp_v);
      end
      checks++;
      if (d_drop_cnt !== 8'd2) begin
         errors++;
         $display("FAIL reset_prefill_drop: drop=%0d want 2", d_drop_cnt);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== '0 || out_data !== '0 || d_drop_cnt !== '0 || d_out_valid !== '0) begin
         errors++;
         $display("FAIL reset_async: valid=%h data=%h drop=%0d, want all zero", out_valid, out_data, d_drop_cnt);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      checks++;
      if (out_valid !== '0) begin
         errors++;
         $display("FAIL reset_no_redeliver: valid=%h want 0", out_valid);
      end
   endtask

   task automatic test_route_all();
      logic [NL-1:0] exp_v;
      out_ready = '1;
      for (int k = 0; k < NL; k++) begin
         in_valid = 1'b1;
         in_sel   = SEL_W'(k);
         in_data  = DATA_W'(k);
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL route_ready lane %0d: got %b want 1", k, in_ready);
         end
         @(posedge clk);
         #1;
         exp_v = '0;
         exp_v[k] = 1'b1;
         checks++;
         if (out_valid !== exp_v || lane(out_data, k) !== DATA_W'(k % 4)) begin
            errors++;
            $display("FAIL route lane %0d: valid=%h data=%0d want valid=%h data=%0d",
                     k, out_valid, lane(out_data, k), exp_v, k % 4);
         end
      end
      idle();
      step();
      checks++;
      if (out_valid !== '0) begin
         errors++;
         $display("FAIL route_drain: valid=%h want 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = '1;
      out_ready[5] = 1'b0;
      in_valid = 1'b1; in_sel = 5'd5; in_data = 2'b10;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_first_ready: got %b want 1", in_ready);
      end
      step();
      in_data = 2'b01;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_stall_ready: got %b want 0", in_ready);
      end
      step();
      checks++;
      if (out_valid[5] !== 1'b1 || lane(out_data, 5) !== 2'b10) begin
         errors++;
         $display("FAIL bp_hold: valid=%b data=%b want 1 10", out_valid[5], lane(out_data, 5));
      end
      out_ready[5] = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_comb_ready: got %b want 1", in_ready);
      end
      step();
      idle();
      checks++;
      if (out_valid[5] !== 1'b1 || lane(out_data, 5) !== 2'b01) begin
         errors++;
         $display("FAIL bp_refill: valid=%b data=%b want 1 01", out_valid[5], lane(out_data, 5));
      end
      step();
      checks++;
      if (out_valid !== '0 || lane(out_data, 5) !== 2'b01) begin
         errors++;
         $display("FAIL bp_empty_hold: valid=%h data=%b want 0 01", out_valid, lane(out_data, 5));
      end
   endtask

   task automatic test_independence();
      logic [NL-1:0] exp_v;
      out_ready = '1;
      out_ready[5] = 1'b0;
      in_valid = 1'b1; in_sel = 5'd5; in_data = 2'b10;
      step();
      in_sel = 5'd6; in_data = 2'b11;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL indep_ready: got %b want 1", in_ready);
      end
      step();
      idle();
      exp_v = '0; exp_v[5] = 1'b1; exp_v[6] = 1'b1;
      checks++;
      if (out_valid !== exp_v || lane(out_data, 6) !== 2'b11 || lane(out_data, 5) !== 2'b10) begin
         errors++;
         $display("FAIL indep: valid=%h l5=%b l6=%b want %h 10 11",
                  out_valid, lane(out_data, 5), lane(out_data, 6), exp_v);
      end
      step();
      exp_v[6] = 1'b0;
      checks++;
      if (out_valid !== exp_v || lane(out_data, 5) !== 2'b10) begin
         errors++;
         $display("FAIL indep_stall: valid=%h l5=%b want %h 10", out_valid, lane(out_data, 5), exp_v);
      end
      // Garbage on sel/data with in_valid low must not disturb anything.
      in_sel = 5'bx; in_data = 2'bx;
      step();
      step();
      checks++;
      if (out_valid !== exp_v || lane(out_data, 5) !== 2'b10 || drop_cnt !== '0) begin
         errors++;
         $display("FAIL idle_x: valid=%h l5=%b drop=%0d want %h 10 0",
                  out_valid, lane(out_data, 5), drop_cnt, exp_v);
      end
      idle();
      out_ready = '1;
      step();
      checks++;
      if (out_valid !== '0) begin
         errors++;
         $display("FAIL indep_drain: valid=%h want 0", out_valid);
      end
   endtask

   task automatic test_drop();
      logic [CNT_W-1:0] exp_cnt;
      logic [NL_D-1:0]  exp_v;
      d_out_ready = '1;
      for (int n = 1; n <= 300; n++) begin
         d_in_valid = 1'b1;
         d_in_sel   = (n % 2 == 1) ? 5'd30 : 5'd31;
         d_in_data  = DATA_W'(n);
         #1;
         checks++;
         if (d_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drop_ready beat %0d: got %b want 1", n, d_in_ready);
         end
         step();
         exp_cnt = (n > 255) ? 8'd255 : CNT_W'(n);
         checks++;
         if (d_drop_cnt !== exp_cnt || d_out_valid !== '0) begin
            errors++;
            $display("FAIL drop beat %0d: cnt=%0d valid=%h want cnt=%0d valid=0",
                     n, d_drop_cnt, d_out_valid, exp_cnt);
         end
      end
      d_in_sel = 5'd29; d_in_data = 2'b11;
      #1;
      checks++;
      if (d_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL drop_top_lane_ready: got %b want 1", d_in_ready);
      end
      step();
      idle();
      exp_v = '0; exp_v[29] = 1'b1;
      checks++;
      if (d_out_valid !== exp_v || d_out_data[29*DATA_W +: DATA_W] !== 2'b11 || d_drop_cnt !== 8'd255) begin
         errors++;
         $display("FAIL drop_top_lane: valid=%h data=%b cnt=%0d want %h 11 255",
                  d_out_valid, d_out_data[29*DATA_W +: DATA_W], d_drop_cnt, exp_v);
      end
      step();
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] sb [NL][$];
      logic [NL-1:0]     exp_v;
      logic              exp_ready;
      int                sent = 0;
      int                got  = 0;
      for (int c = 0; c < 10000; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_sel    = SEL_W'($urandom_range(0, NL - 1));
         in_data   = DATA_W'($urandom_range(0, 3));
         out_ready = $urandom | $urandom;
         #1;
         exp_ready = (sb[in_sel].size() == 0) || out_ready[in_sel];
         for (int i = 0; i < NL; i++) exp_v[i] = (sb[i].size() != 0);
         checks++;
         if (in_ready !== exp_ready) begin
            errors++;
            if (errors < 20) $display("FAIL rand_ready cyc %0d: got %b want %b", c, in_ready, exp_ready);
         end
         checks++;
         if (out_valid !== exp_v) begin
            errors++;
            if (errors < 20) $display("FAIL rand_valid cyc %0d: got %h want %h", c, out_valid, exp_v);
         end
         for (int i = 0; i < NL; i++) begin
            if (exp_v[i]) begin
               checks++;
               if (lane(out_data, i) !== sb[i][0]) begin
                  errors++;
                  if (errors < 20) $display("FAIL rand_data cyc %0d lane %0d: got %0d want %0d",
                                            c, i, lane(out_data, i), sb[i][0]);
               end
               if (out_ready[i]) begin
                  void'(sb[i].pop_front());
                  got++;
               end
            end
         end
         if (in_valid && exp_ready) begin
            sb[in_sel].push_back(in_data);
            sent++;
         end
         step();
      end
      idle();
      out_ready = '1;
      for (int i = 0; i < NL; i++) begin
         if (sb[i].size() != 0) begin
            checks++;
            if (out_valid[i] !== 1'b1 || lane(out_data, i) !== sb[i][0]) begin
               errors++;
               $display("FAIL rand_final lane %0d: valid=%b data=%0d want 1 %0d",
                        i, out_valid[i], lane(out_data, i), sb[i][0]);
            end
            void'(sb[i].pop_front());
            got++;
         end
      end
      step();
      checks++;
      if (out_valid !== '0 || got != sent) begin
         errors++;
         $display("FAIL rand_drain: valid=%h delivered=%0d want valid=0 delivered=%0d", out_valid, got, sent);
      end
   endtask

   initial begin
      idle();
      out_ready   = '0;
      d_out_ready = '0;
      test_reset();
      test_route_all();
      test_backpressure();
      test_independence();
      test_drop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
